// File: rtl/timing_recover.sv
// Video timing recovery: rebuilds row/col/pixel-valid from received syncs and
// data enable, and tracks lock against the expected active geometry.
module timing_recover #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        vde,
  output logic [9:0]  row,
  output logic [9:0]  col,
  output logic        pix_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        err_width,
  output logic        err_height,
  output logic [15:0] frame_count
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned GOOD_W = 3;
  localparam int unsigned FC_W   = 16;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [LEN_W-1:0]  H_LEN     = LEN_W'(H_ACTIVE);
  localparam logic [LEN_W-1:0]  V_LEN     = LEN_W'(V_ACTIVE);
  localparam logic [GOOD_W-1:0] GOOD_NEED = GOOD_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state;
  logic [GOOD_W-1:0] good_cnt;
  logic              frame_bad;

  logic hs_q1, vs_q1, de_q1;
  logic hs_q2, vs_q2, de_q2;

  logic             hs_edge, vs_edge, de_rise, de_fall;
  logic             checking, width_bad, height_bad, frame_ok;
  logic [LEN_W-1:0] line_len, lines_done;

  // Edge detection and geometry checks on the registered input stage
  always_comb begin
    hs_edge    = hs_q1 & ~hs_q2;
    vs_edge    = vs_q1 & ~vs_q2;
    de_rise    = de_q1 & ~de_q2;
    de_fall    = ~de_q1 & de_q2;
    checking   = (state != SEARCH);
    line_len   = LEN_W'(col) + LEN_W'(1);
    lines_done = LEN_W'(row) + LEN_W'(de_fall);
    width_bad  = de_fall && (line_len != H_LEN);
    height_bad = (lines_done != V_LEN);
    frame_ok   = !frame_bad && !width_bad && !height_bad;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_q1       <= 1'b0;
      vs_q1       <= 1'b0;
      de_q1       <= 1'b0;
      hs_q2       <= 1'b0;
      vs_q2       <= 1'b0;
      de_q2       <= 1'b0;
      row         <= '0;
      col         <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
      frame_count <= '0;
      frame_bad   <= 1'b0;
      good_cnt    <= '0;
      state       <= SEARCH;
    end else begin
      // Syncs are normalised to active-high before the edge detector
      hs_q1 <= hsync ~^ SYNC_POL;
      vs_q1 <= vsync ~^ SYNC_POL;
      de_q1 <= vde;
      hs_q2 <= hs_q1;
      vs_q2 <= vs_q1;
      de_q2 <= de_q1;

      line_start  <= hs_edge;
      frame_start <= vs_edge;
      pix_valid   <= de_q1 && checking;
      err_width   <= checking && width_bad;
      err_height  <= checking && vs_edge && height_bad;
      locked      <= (state == LOCKED);

      if (de_q1) begin
        if (de_rise)              col <= '0;
        else if (col != CNT_MAX)  col <= col + CNT_W'(1);
      end

      // A vsync edge wins over a coincident line end
      if (vs_edge)                        row <= '0;
      else if (de_fall && row != CNT_MAX) row <= row + CNT_W'(1);

      if (vs_edge)        frame_bad <= 1'b0;
      else if (width_bad) frame_bad <= 1'b1;

      case (state)
        SEARCH: begin
          if (vs_edge) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (vs_edge) begin
            if (!frame_ok) begin
              good_cnt <= '0;
            end else if (good_cnt + GOOD_W'(1) == GOOD_NEED) begin
              state       <= LOCKED;
              good_cnt    <= '0;
              frame_count <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end
          end
        end
        LOCKED: begin
          if (width_bad || (vs_edge && height_bad)) state       <= SEARCH;
          else if (vs_edge)                         frame_count <= frame_count + FC_W'(1);
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: doc/timing_recover.md
TIMING_RECOVER -- requirements
Module: timing_recover

Interface
REQ-001 Parameter: H_ACTIVE, 800, expected vde-high cycles per line.
REQ-002 Parameter: V_ACTIVE, 600, expected active lines per frame.
REQ-003 Parameter: SYNC_POL, 1, active level of hsync/vsync (1 = active-high).
REQ-004 Parameter: LOCK_FRAMES, 2, consecutive good frames required to lock (1..7).
REQ-005 Port: clock  input  1  pixel clock; sole clock; all state rising-edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: hsync  input  1  received horizontal sync.
REQ-008 Port: vsync  input  1  received vertical sync.
REQ-009 Port: vde  input  1  received data enable; high = active pixel.
REQ-010 Port: row  output  10  recovered line index of current active pixel.
REQ-011 Port: col  output  10  recovered pixel index within line.
REQ-012 Port: pix_valid  output  1  row/col describe an active pixel this cycle.
REQ-013 Port: line_start  output  1  one-cycle pulse on hsync active edge.
REQ-014 Port: frame_start  output  1  one-cycle pulse on vsync active edge.
REQ-015 Port: locked  output  1  timing matches parameters for LOCK_FRAMES frames.
REQ-016 Port: err_width  output  1  one-cycle pulse: active line length != H_ACTIVE.
REQ-017 Port: err_height  output  1  one-cycle pulse: active lines at frame end != V_ACTIVE.
REQ-018 Port: frame_count  output  16  completed frames since lock, wraps 65535 -> 0.

Function
REQ-019 Inputs shall be registered once; edges detected against a second register; all outputs registered; output latency = 2 cycles from input pin to row/col/pix_valid/pulses.
REQ-020 Active edge = transition into SYNC_POL level; for SYNC_POL=0 polarity shall be inverted before edge detect.
REQ-021 col shall be 0 on first vde-high cycle of a line, +1 each further vde-high cycle, saturating at 1023.
REQ-022 row shall be 0 for first active line after a vsync active edge, +1 on each vde falling edge, saturating at 1023.
REQ-023 pix_valid shall follow delayed vde in states MEASURE and LOCKED; forced 0 in SEARCH.
REQ-024 On vde falling edge, if pixel count != H_ACTIVE, err_width shall pulse (MEASURE or LOCKED only).
REQ-025 On vsync active edge, if completed-line count != V_ACTIVE, err_height shall pulse (MEASURE or LOCKED only).
REQ-026 FSM states: SEARCH, MEASURE, LOCKED.
REQ-027 SEARCH -> MEASURE on first vsync active edge; good-frame counter cleared.
REQ-028 MEASURE: at each vsync active edge, frame with no err_width and correct height increments good counter, else clears it; counter reaching LOCK_FRAMES -> LOCKED.
REQ-029 LOCKED: any err_width or err_height -> SEARCH same edge; locked deasserts the following cycle.
REQ-030 locked shall equal (state == LOCKED), registered.
REQ-031 frame_count shall increment at each vsync active edge while LOCKED, clear on entering LOCKED.
REQ-032 vsync edge and vde high in same cycle: row reset takes priority, pixel reported as row 0.
REQ-033 vde high during vsync active level shall still count; vde glitch of 1 cycle counts as a 1-pixel line (err_width).

Reset
REQ-034 While reset high: state SEARCH, row=0, col=0, pix_valid=0, all pulses 0, locked=0, frame_count=0, good counter 0, input registers 0 (inactive after polarity).
REQ-035 Reset deassertion mid-frame shall discard partial frame; lock requires a fresh vsync edge plus LOCK_FRAMES good frames.

Verification
REQ-036 Clean 800x600 SVGA (40 MHz timing, positive syncs) from reset -> locked rises 1 cycle after 3rd vsync edge; no error pulses.
REQ-037 Locked, pixel at line 599 col 799 -> row=599, col=799, pix_valid=1 two cycles after vde sample.
REQ-038 Locked, one line with 799 active pixels -> err_width pulse, locked low next cycle, relock after 3 further clean vsync edges.
REQ-039 Locked, frame with 601 lines -> err_height on next vsync edge, state SEARCH, frame_count held then cleared on relock.
REQ-040 SYNC_POL=0 with inverted syncs -> identical row/col/locked behaviour to REQ-036.
REQ-041 Reset asserted at row 300 while locked -> all outputs 0 asynchronously; locked low until 3rd clean vsync edge after release.
